// File: rtl/island_prog_sequencer.sv
// island_prog_sequencer
// Sequences one floating-gate programming command: decodes the target
// row/column, settles the program path, then issues a train of hot-electron
// injection pulses separated by gaps and reports completion on done.
// Optional build macro: PROG_ERASE_EN adds the cmd_erase input and tun_en
// output so a command can instead run a single tunnelling (erase) phase.
module island_prog_sequencer #(
  parameter int NUM_ROWS   = 12,
  parameter int NUM_COLS   = 19,
  parameter int ROW_BITS   = $clog2(NUM_ROWS),
  parameter int COL_BITS   = $clog2(NUM_COLS),
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int PULSE_CYC  = 8,
  parameter int GAP_CYC    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [CNT_W-1:0]    cmd_count,
`ifdef PROG_ERASE_EN
  input  logic                cmd_erase,
  output logic                tun_en,
`endif
  input  logic                abort,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic [NUM_ROWS-1:0] drain_sel,
  output logic                prog_en,
  output logic                vinj_pulse,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                err
);

  // Phase counter is sized for the longest of the three phases.
  localparam int MAX_SP  = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  // Counter reload values: each phase counts down to zero, so load length-1.
  localparam logic [CYC_W-1:0] SET_LD = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] PUL_LD = CYC_W'(PULSE_CYC - 1);
  localparam logic [CYC_W-1:0] GAP_LD = CYC_W'(GAP_CYC - 1);

  // One extra bit so the limit itself is representable for the range check.
  localparam logic [ROW_BITS:0] ROW_LIM = (ROW_BITS + 1)'(NUM_ROWS);
  localparam logic [COL_BITS:0] COL_LIM = (COL_BITS + 1)'(NUM_COLS);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                abrt_q, abrt_d;
  logic                err_q, err_d;
  logic                erase_mode;
  logic                range_bad;
  logic                active;

`ifdef PROG_ERASE_EN
  logic                erase_q, erase_d;
  assign erase_mode = erase_q;
`else
  assign erase_mode = 1'b0;
`endif

  assign range_bad = ({1'b0, cmd_row} >= ROW_LIM) || ({1'b0, cmd_col} >= COL_LIM);

  // State, phase counter, remaining-pulse count and latched command fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      rem_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      abrt_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_ERASE_EN
      erase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      rem_q   <= rem_d;
      row_q   <= row_d;
      col_q   <= col_d;
      abrt_q  <= abrt_d;
      err_q   <= err_d;
`ifdef PROG_ERASE_EN
      erase_q <= erase_d;
`endif
    end
  end

  // Next-state logic: command accept, phase sequencing and abort handling.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    rem_d   = rem_q;
    row_d   = row_q;
    col_d   = col_q;
    abrt_d  = abrt_q;
    err_d   = 1'b0;
`ifdef PROG_ERASE_EN
    erase_d = erase_q;
`endif
    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here; only an active command can be aborted
        if (cmd_valid) begin
`ifdef PROG_ERASE_EN
          if (cmd_erase) begin
            // erase is a single pulse-length phase with no address decode
            erase_d = 1'b1;
            abrt_d  = 1'b0;
            rem_d   = CNT_W'(1);
            cyc_d   = SET_LD;
            state_d = SETTLE;
          end else
`endif
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            row_d  = cmd_row;
            col_d  = cmd_col;
            rem_d  = cmd_count;
            abrt_d = 1'b0;
`ifdef PROG_ERASE_EN
            erase_d = 1'b0;
`endif
            if (cmd_count == '0) begin
              state_d = DONE;
            end else begin
              cyc_d   = SET_LD;
              state_d = SETTLE;
            end
          end
        end
      end
      SETTLE, PULSE, GAP: begin
        if (abort) begin
          abrt_d  = 1'b1;
          state_d = DONE;
        end else if (cyc_q != '0) begin
          cyc_d = cyc_q - CYC_W'(1);
        end else begin
          case (state_q)
            SETTLE: begin
              cyc_d   = PUL_LD;
              state_d = PULSE;
            end
            PULSE: begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = DONE;
              end else begin
                cyc_d   = GAP_LD;
                state_d = GAP;
              end
            end
            default: begin
              cyc_d   = PUL_LD;
              state_d = PULSE;
            end
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    active     = (state_q == SETTLE) || (state_q == PULSE) || (state_q == GAP);
    cmd_ready  = (state_q == IDLE);
    busy       = active;
    done       = (state_q == DONE);
    aborted    = (state_q == DONE) && abrt_q;
    err        = err_q;
    prog_en    = active && !erase_mode;
    vinj_pulse = (state_q == PULSE) && !erase_mode;
    drain_sel  = prog_en ? (NUM_ROWS'(1) << row_q) : '0;
    row_addr   = row_q;
    col_addr   = col_q;
`ifdef PROG_ERASE_EN
    tun_en     = (state_q == PULSE) && erase_mode;
`endif
  end

endmodule

// File: doc/island_prog_sequencer.md
ISLAND_PROG_SEQUENCER -- requirements
Module: island_prog_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 12, number of drain-select rows (vertical decode).
REQ-002 SHALL have parameter NUM_COLS, default 19, number of indirect-switch columns (horizontal decode).
REQ-003 SHALL have parameters ROW_BITS = clog2(NUM_ROWS) and COL_BITS = clog2(NUM_COLS), derived, address widths.
REQ-004 SHALL have parameter CNT_W, default 8, pulse-count field width.
REQ-005 SHALL have parameters SETTLE_CYC (default 4), PULSE_CYC (default 8) and GAP_CYC (default 2), each >=1, phase lengths in clk cycles.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-009 cmd_row  in  ROW_BITS; cmd_col  in  COL_BITS; cmd_count  in  CNT_W  injection pulses requested.
REQ-010 abort  in  1  terminate current command.
REQ-011 row_addr  out  ROW_BITS; col_addr  out  COL_BITS  decoder addresses.
REQ-012 drain_sel  out  NUM_ROWS  one-hot drain select; prog_en  out  1  program-switch enable; vinj_pulse  out  1  injection pulse.
REQ-013 busy  out  1; done  out  1  one-cycle completion; aborted  out  1  qualifies done; err  out  1  one-cycle range error.

Function
REQ-014 States SHALL be IDLE, SETTLE, PULSE, GAP, DONE; cmd_ready SHALL be high exactly in IDLE.
REQ-015 On accept, SHALL register row/col/count; if cmd_row>=NUM_ROWS or cmd_col>=NUM_COLS, SHALL pulse err next cycle and stay IDLE.
REQ-016 Valid accept with cmd_count=0 SHALL go directly to DONE (done=1, aborted=0), no prog_en.
REQ-017 Valid accept with count>0 SHALL enter SETTLE; in SETTLE/PULSE/GAP row_addr/col_addr hold registered values, drain_sel=1<<row, prog_en=1, busy=1.
REQ-018 SETTLE SHALL last SETTLE_CYC cycles, then PULSE.
REQ-019 PULSE SHALL assert vinj_pulse for exactly PULSE_CYC cycles, decrementing remaining count by one at its end.
REQ-020 After PULSE, remaining>0 SHALL enter GAP (vinj_pulse=0, GAP_CYC cycles) then PULSE; remaining=0 SHALL enter DONE.
REQ-021 Total cycles accept-to-done SHALL be 1+SETTLE_CYC+N*PULSE_CYC+(N-1)*GAP_CYC for N pulses.
REQ-022 DONE SHALL last one cycle: done=1, prog_en=0, drain_sel=0, vinj_pulse=0, busy=0; then IDLE.
REQ-023 abort high in SETTLE/PULSE/GAP SHALL force DONE next cycle with aborted=1, vinj_pulse dropping that edge; abort in IDLE/DONE SHALL be ignored, even with cmd_valid.
REQ-024 Outside SETTLE/PULSE/GAP, drain_sel, prog_en, vinj_pulse SHALL be 0; row_addr/col_addr hold last values.
REQ-025 vinj_pulse SHALL never be high while prog_en is low.

Reset
REQ-026 reset SHALL asynchronously force IDLE, counters 0, row_addr=0, col_addr=0, drain_sel=0, prog_en=0, vinj_pulse=0, busy=0, done=0, aborted=0, err=0.
REQ-027 reset mid-PULSE SHALL drop vinj_pulse and prog_en immediately without done; cmd_ready SHALL be 1 first edge after release.

Configuration
REQ-028 With PROG_ERASE_EN defined, SHALL add input cmd_erase (1) and output tun_en (1): an accepted erase ignores row/col/count and range check, runs SETTLE then one PULSE-length phase with tun_en=1, prog_en=0, drain_sel=0, vinj_pulse=0, then DONE; abort applies.
REQ-029 Without PROG_ERASE_EN, cmd_erase and tun_en SHALL not exist and all commands are injection commands.

Verification
REQ-030 row=3, col=5, count=2, defaults -> drain_sel=0x008, prog_en 1 for 4+8+2+8=22 cycles, two 8-cycle vinj_pulse, done at cycle 23 after accept.
REQ-031 row=12 (NUM_ROWS=12), count=5 -> err pulse next cycle, prog_en never high, cmd_ready stays 1.
REQ-032 count=0 -> done=1, aborted=0 cycle after accept, drain_sel stays 0.
REQ-033 count=3, abort on 4th cycle of first PULSE -> vinj_pulse low next edge, done=1 & aborted=1 one cycle, then IDLE.
REQ-034 reset mid-GAP of count=4 -> all outputs 0 asynchronously, no done; new command accepted after release.
REQ-035 PROG_ERASE_EN, cmd_erase=1 -> tun_en high 8 cycles after 4-cycle settle, prog_en=0 throughout, done at cycle 13.
